// File: rtl/value_ramp_expand.sv
// value_ramp_expand
// Takes a narrowed, already-limited servo output word and rebuilds the
// full-width signed value. It re-applies the min/max limits and then slews
// the registered output toward that target in fixed steps, one step per
// programmable tick. busy is high while a ramp is in progress. done pulses
// for one cycle when the output lands on the target.

module value_ramp_expand #(
  parameter int                            INPUT_BITS  = 16,
  parameter int                            OUTPUT_MSB  = 15,
  parameter int                            OUTPUT_LSB  = 5,
  parameter logic signed [INPUT_BITS-1:0]  OUTPUT_MIN  = 16'sh0000,
  parameter logic signed [INPUT_BITS-1:0]  OUTPUT_MAX  = 16'sh7fff,
  parameter int                            TICK_DIV    = 1,
  parameter logic signed [INPUT_BITS-1:0]  RESET_VALUE = 16'sh0000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [OUTPUT_MSB-OUTPUT_LSB:0]      in_word,
  input  logic [INPUT_BITS-1:0]               step,
  output logic signed [INPUT_BITS-1:0]        value,
  output logic                                busy,
  output logic                                done,
  output logic                                target_clipped
);

  localparam int W     = OUTPUT_MSB - OUTPUT_LSB + 1;
  localparam int CNT_W = 16;
  // Counter value on which a ramp step fires (TICK_DIV is 1..65535).
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // Place the narrow word back at its bit position. When the slice reaches
  // the top bit, the word's msb becomes the sign bit, so this is sign
  // extension. Otherwise the bits above the slice stay zero.
  function automatic logic signed [INPUT_BITS-1:0] expand_word(
    input logic [W-1:0] word
  );
    logic [INPUT_BITS-1:0] ext;
    ext = '0;
    ext[OUTPUT_MSB:OUTPUT_LSB] = word;
    return $signed(ext);
  endfunction

  // Clamp an expanded value into [OUTPUT_MIN, OUTPUT_MAX] using signed compares.
  function automatic logic signed [INPUT_BITS-1:0] limit_word(
    input logic signed [INPUT_BITS-1:0] ext
  );
    logic signed [INPUT_BITS-1:0] res;
    if (ext < OUTPUT_MIN) begin
      res = OUTPUT_MIN;
    end else if (ext > OUTPUT_MAX) begin
      res = OUTPUT_MAX;
    end else begin
      res = ext;
    end
    return res;
  endfunction

  // True when limit_word would change the value.
  function automatic logic is_clipped(
    input logic signed [INPUT_BITS-1:0] ext
  );
    logic res;
    if ((ext < OUTPUT_MIN) || (ext > OUTPUT_MAX)) begin
      res = 1'b1;
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  state_t                        state_r, state_s;
  logic signed [INPUT_BITS-1:0]  value_r, value_s;
  logic signed [INPUT_BITS-1:0]  target_r, target_s;
  logic [CNT_W-1:0]              cnt_r, cnt_s;
  logic                          done_r, done_s;
  logic                          busy_r;
  logic                          clip_r, clip_s;

  logic signed [INPUT_BITS-1:0]  ext_s;
  logic signed [INPUT_BITS:0]    diff_s;
  logic [INPUT_BITS:0]           mag_s;
  logic                          tick_s;
  logic                          land_s;

  // Datapath helpers: expanded input, and the one-bit-wider distance to target.
  always_comb begin
    ext_s  = expand_word(in_word);
    diff_s = $signed({target_r[INPUT_BITS-1], target_r})
           - $signed({value_r[INPUT_BITS-1], value_r});
    if (diff_s[INPUT_BITS]) begin
      mag_s = $unsigned(-diff_s);
    end else begin
      mag_s = $unsigned(diff_s);
    end
    tick_s = (state_r == ST_RAMP) && (cnt_r == TICK_LAST);
    land_s = (step == '0) || (mag_s <= {1'b0, step});
  end

  // Next-state and next-datapath logic. A new word always wins over a
  // tick in the same cycle, so an abandoned ramp never reports done.
  always_comb begin
    state_s  = state_r;
    value_s  = value_r;
    target_s = target_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    clip_s   = clip_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          target_s = limit_word(ext_s);
          clip_s   = is_clipped(ext_s);
          cnt_s    = '0;
          state_s  = ST_RAMP;
        end else begin
          cnt_s    = '0;
        end
      end
      ST_RAMP: begin
        if (in_valid) begin
          target_s = limit_word(ext_s);
          clip_s   = is_clipped(ext_s);
          cnt_s    = '0;
          state_s  = ST_RAMP;
        end else if (tick_s) begin
          cnt_s = '0;
          if (land_s) begin
            value_s = target_r;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else if (!diff_s[INPUT_BITS]) begin
            // Distance exceeds step, so this cannot pass the target.
            value_s = value_r + step;
          end else begin
            value_s = value_r - step;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      value_r  <= RESET_VALUE;
      target_r <= RESET_VALUE;
      cnt_r    <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      clip_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      value_r  <= value_s;
      target_r <= target_s;
      cnt_r    <= cnt_s;
      done_r   <= done_s;
      busy_r   <= (state_s == ST_RAMP);
      clip_r   <= clip_s;
    end
  end

  assign value          = value_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign target_clipped = clip_r;

endmodule

// File: tb/tb_value_ramp_expand.sv
// Bench for value_ramp_expand: two instances (default limits with
// TICK_DIV=1, and narrow limits with TICK_DIV=4) run on shared stimulus.
// An integer-arithmetic reference model checks them every cycle.
// Literal expectations from the directed scenarios also pin the model.

module tb_value_ramp_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [10:0] in_word;
  logic [15:0] step;

  logic [15:0] value_a, value_b;
  logic        busy_a, busy_b, done_a, done_b, clip_a, clip_b;

  int vectors = 0;
  int miscompares = 0;

  value_ramp_expand #(
    .INPUT_BITS(16), .OUTPUT_MSB(15), .OUTPUT_LSB(5),
    .OUTPUT_MIN(16'sh0000), .OUTPUT_MAX(16'sh7fff),
    .TICK_DIV(1), .RESET_VALUE(16'sh0000)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .step(step),
    .value(value_a), .busy(busy_a), .done(done_a), .target_clipped(clip_a)
  );

  value_ramp_expand #(
    .INPUT_BITS(16), .OUTPUT_MSB(15), .OUTPUT_LSB(5),
    .OUTPUT_MIN(16'she000), .OUTPUT_MAX(16'sh3000),
    .TICK_DIV(4), .RESET_VALUE(16'sh0100)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .step(step),
    .value(value_b), .busy(busy_b), .done(done_b), .target_clipped(clip_b)
  );

  // Reference model: plain integers, one entry per instance.
  typedef struct {
    int value;
    int target;
    int since;   // cycles elapsed since acceptance or the last step
    bit busy;
    bit done;
    bit clip;
  } model_t;

  model_t m [2];
  int     tdiv [2] = '{1, 4};
  int     lo   [2] = '{0, -8192};
  int     hi   [2] = '{32767, 12288};
  int     rval [2] = '{0, 256};
  bit     model_live = 1'b0;

  function automatic int expand(input int w);
    int e;
    e = w * 32;
    if (e > 32767) e = e - 65536;
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int e, d, ad, s;
      m[k].done = 1'b0;
      s = int'(step);
      if (rst) begin
        m[k].value  = rval[k];
        m[k].target = rval[k];
        m[k].since  = 0;
        m[k].busy   = 1'b0;
        m[k].clip   = 1'b0;
      end else if (in_valid) begin
        e = expand(int'(in_word));
        m[k].clip   = (e < lo[k]) || (e > hi[k]);
        m[k].target = (e < lo[k]) ? lo[k] : ((e > hi[k]) ? hi[k] : e);
        m[k].since  = 0;
        m[k].busy   = 1'b1;
      end else if (m[k].busy) begin
        m[k].since = m[k].since + 1;
        if (m[k].since == tdiv[k]) begin
          m[k].since = 0;
          d  = m[k].target - m[k].value;
          ad = (d < 0) ? -d : d;
          if (s == 0 || ad <= s) begin
            m[k].value = m[k].target;
            m[k].done  = 1'b1;
            m[k].busy  = 1'b0;
          end else begin
            m[k].value = (d > 0) ? m[k].value + s : m[k].value - s;
          end
        end
      end
    end
    if (rst) model_live = 1'b1;
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check16("a.value", value_a, 16'(m[0].value));
      check1 ("a.busy",  busy_a,  m[0].busy);
      check1 ("a.done",  done_a,  m[0].done);
      check1 ("a.clip",  clip_a,  m[0].clip);
      check16("b.value", value_b, 16'(m[1].value));
      check1 ("b.busy",  busy_b,  m[1].busy);
      check1 ("b.done",  done_b,  m[1].done);
      check1 ("b.clip",  clip_b,  m[1].clip);
    end
  end

  // Literal expectation on instance A: pins both the model and the DUT.
  task automatic lit_a(input string name, input logic [15:0] v, input logic d, input logic b);
    check16({name, ".model_value"}, 16'(m[0].value), v);
    check16({name, ".value"}, value_a, v);
    check1 ({name, ".done"},  done_a,  d);
    check1 ({name, ".busy"},  busy_a,  b);
  endtask

  task automatic lit_b(input string name, input logic [15:0] v, input logic d, input logic b);
    check16({name, ".model_value"}, 16'(m[1].value), v);
    check16({name, ".value"}, value_b, v);
    check1 ({name, ".done"},  done_b,  d);
    check1 ({name, ".busy"},  busy_b,  b);
  endtask

  task automatic accept(input logic [10:0] w, input logic [15:0] s);
    in_word  = w;
    step     = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick_step();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 256));
      2:       return 16'($urandom_range(256, 8192));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = 11'h000; step = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    lit_a("rst_a", 16'h0000, 1'b0, 1'b0);
    check1("rst_a.clip", clip_a, 1'b0);
    lit_b("rst_b", 16'h0100, 1'b0, 1'b0);

    // Negative expansion clipped to zero; done on first tick, value held.
    accept(11'h7FF, 16'h0080);
    lit_a("clip_acc", 16'h0000, 1'b0, 1'b1);
    check1("clip_acc.clip", clip_a, 1'b1);
    @(negedge clk);
    lit_a("clip_done", 16'h0000, 1'b1, 1'b0);

    // Ramp 0 -> 0x0200 by 0x0080.
    accept(11'h010, 16'h0080);
    lit_a("ramp_acc", 16'h0000, 1'b0, 1'b1);
    check1("ramp_acc.clip", clip_a, 1'b0);
    @(negedge clk); lit_a("ramp1", 16'h0080, 1'b0, 1'b1);
    @(negedge clk); lit_a("ramp2", 16'h0100, 1'b0, 1'b1);
    @(negedge clk); lit_a("ramp3", 16'h0180, 1'b0, 1'b1);
    @(negedge clk); lit_a("ramp4", 16'h0200, 1'b1, 1'b0);
    @(negedge clk); lit_a("ramp_idle", 16'h0200, 1'b0, 1'b0);

    // Downward ramp with the last step shortened to land on 0x0020.
    accept(11'h001, 16'h0100);
    @(negedge clk); lit_a("down1", 16'h0100, 1'b0, 1'b1);
    @(negedge clk); lit_a("down2", 16'h0020, 1'b1, 1'b0);
    check1("down2.clip", clip_a, 1'b0);

    // Retarget mid-ramp: the new word wins over the coinciding tick.
    do_reset();
    accept(11'h3FF, 16'h1000);
    @(negedge clk); lit_a("rt1", 16'h1000, 1'b0, 1'b1);
    @(negedge clk); lit_a("rt2", 16'h2000, 1'b0, 1'b1);
    accept(11'h020, 16'h1000);
    lit_a("rt_acc", 16'h2000, 1'b0, 1'b1);
    @(negedge clk); lit_a("rt3", 16'h1000, 1'b0, 1'b1);
    @(negedge clk); lit_a("rt4", 16'h0400, 1'b1, 1'b0);

    // TICK_DIV=4 with step 0: jump 4 cycles after acceptance.
    do_reset();
    accept(11'h010, 16'h0000);
    lit_b("td_acc", 16'h0100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lit_b("td_wait", 16'h0100, 1'b0, 1'b1);
    end
    @(negedge clk); lit_b("td_jump", 16'h0200, 1'b1, 1'b0);

    // Reset during a second ramp: back to reset value, no done.
    accept(11'h030, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lit_b("td_rst", 16'h0100, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); lit_b("td_after_rst", 16'h0100, 1'b0, 1'b0);
    end

    // Randomized traffic, checked by the per-cycle compare process.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 5) == 0);
      in_word  = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) step = pick_step();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
